// File: rtl/fx_match_pipe.sv
// Fixed-point Q-format converter: quantize (selectable rounding) then
// overflow handling (saturate or wrap), with valid strobe and a saturating overflow count.
module fx_match_pipe #(
  parameter int IW = 14,
  parameter int IF = 10,
  parameter int OW = 15,
  parameter int OF = 10,
  parameter int CW = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic signed [IW-1:0] i_data,
  input  logic [1:0]           i_rnd_mode,
  input  logic                 i_sat_en,
  input  logic                 i_clr_stat,
  output logic                 o_valid,
  output logic signed [OW-1:0] o_data,
  output logic                 o_ovf,
  output logic [CW-1:0]        o_ovf_cnt
);

  localparam int D   = IF - OF;
  localparam int SH  = (D > 0) ? D : 0;
  localparam int LS  = (D < 0) ? -D : 0;
  localparam int S1W = (D > 0) ? IW - D + 1 : IW - D;
  localparam int QW  = IW + 1 + LS;
  localparam int WM  = ((S1W > OW) ? S1W : OW) + 1;
  localparam int HS  = (SH > 0) ? SH - 1 : 0;

  localparam logic [IW:0] HALF = (IW+1)'(1) << HS;
  localparam logic [IW:0] FULL = ((IW+1)'(1) << SH) - (IW+1)'(1);

  localparam logic signed [WM-1:0] MAXV = {{(WM-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [WM-1:0] MINV = {{(WM-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic [OW-1:0] SAT_HI = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] SAT_LO = {1'b1, {(OW-1){1'b0}}};
  localparam logic [CW-1:0] CNT_MAX = '1;

  // The extra MSB of xe absorbs the rounding carry; SH=0 means no bits are dropped.
  function automatic logic signed [S1W-1:0] quantize(input logic signed [IW-1:0] x,
                                                     input logic [1:0] mode);
    logic signed [IW:0]   xe;
    logic signed [IW:0]   bias;
    logic signed [IW:0]   sum;
    logic signed [QW-1:0] w;
    xe   = (IW+1)'(x);
    bias = '0;
    if (SH > 0) begin
      case (mode)
        2'd1:    bias = $signed(HALF);
        2'd2:    bias = $signed(HALF - (IW+1)'(1) + (IW+1)'(xe[SH]));
        2'd3:    bias = x[IW-1] ? $signed(FULL) : '0;
        default: bias = '0;
      endcase
    end
    sum = xe + bias;
    w   = QW'(sum);
    w   = (w >>> SH) <<< LS;
    return w[S1W-1:0];
  endfunction

  // Returns {overflow, result}.
  function automatic logic [OW:0] overflow(input logic signed [S1W-1:0] v, input logic sat);
    logic signed [WM-1:0] vw;
    logic                 fits;
    logic [OW-1:0]        r;
    vw   = WM'(v);
    fits = (vw <= MAXV) && (vw >= MINV);
    if (fits || !sat) r = vw[OW-1:0];
    else if (vw[WM-1]) r = SAT_LO;
    else               r = SAT_HI;
    return {!fits, r};
  endfunction

  logic                  vld_p0, vld_p1;
  logic signed [IW-1:0]  data_p0;
  logic [1:0]            mode_p0;
  logic                  sat_p0, sat_p1;
  logic signed [S1W-1:0] q_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= i_valid;
      vld_p1 <= vld_p0;
    end
  end

  // Input capture: sample and its mode controls travel together
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      data_p0 <= i_data;
      mode_p0 <= i_rnd_mode;
      sat_p0  <= i_sat_en;
    end
  end

  // Stage 1: quantization
  always_ff @(posedge i_clk) begin
    if (vld_p0) begin
      q_p1   <= quantize(data_p0, mode_p0);
      sat_p1 <= sat_p0;
    end
  end

  // Stage 2: overflow handling; outputs hold while no sample completes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ovf   <= 1'b0;
    end else begin
      o_valid <= vld_p1;
      if (vld_p1) {o_ovf, o_data} <= overflow(q_p1, sat_p1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_stat) o_ovf_cnt <= '0;
    else if (o_valid && o_ovf && (o_ovf_cnt != CNT_MAX)) o_ovf_cnt <= o_ovf_cnt + 1'b1;
  end

endmodule

// File: tb/tb_fx_match_pipe.sv
// Directed bench for fx_match_pipe: a 14.10 -> 8.4 converter with a 4-bit counter,
// plus a default-parameter instance (14.10 -> 15.10) sharing the same stimulus.
module tb_fx_match_pipe;

  logic        clk = 1'b0;
  logic        rst, valid, sat, clr;
  logic [13:0] data;
  logic [1:0]  mode;

  logic        a_valid, a_ovf;
  logic [7:0]  a_data;
  logic [3:0]  a_cnt;
  logic        d_valid, d_ovf;
  logic [14:0] d_data;
  logic [15:0] d_cnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fx_match_pipe #(.IW(14), .IF(10), .OW(8), .OF(4), .CW(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_rnd_mode(mode),
    .i_sat_en(sat), .i_clr_stat(clr), .o_valid(a_valid), .o_data(a_data),
    .o_ovf(a_ovf), .o_ovf_cnt(a_cnt)
  );

  fx_match_pipe dut_d (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_rnd_mode(mode),
    .i_sat_en(sat), .i_clr_stat(clr), .o_valid(d_valid), .o_data(d_data),
    .o_ovf(d_ovf), .o_ovf_cnt(d_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample, then two idle edges: its result is visible on return.
  task automatic send(input logic [13:0] v, input logic [1:0] m, input logic s);
    data = v; mode = m; sat = s; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; data = 14'h1FFF; mode = 2'd1; sat = 1'b1; clr = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0; valid = 1'b0;
    n_run++;
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", a_valid); end
    n_run++;
    if (a_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", a_data); end
    n_run++;
    if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
    n_run++;
    if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", a_cnt); end
    n_run++;
    if (d_valid !== 1'b0 || d_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_default got valid=%b cnt=%0d want 0/0", d_valid, d_cnt);
    end
  endtask

  // Default instance has D=0 and one extra integer bit: output is the sign-extended input.
  task automatic test_passthrough();
    logic [13:0] vals[10];
    logic [14:0] exp_d;
    vals[0] = 14'h0000; vals[1] = 14'h1FFF; vals[2] = 14'h2000; vals[3] = 14'h3FFF;
    vals[4] = 14'h0001;
    for (int i = 5; i < 10; i++) vals[i] = 14'($urandom_range(0, 16383));
    mode = 2'd0; sat = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin valid = 1'b1; data = vals[i]; end
      else valid = 1'b0;
      tick();
      if (i >= 2) begin
        exp_d = {vals[i-2][13], vals[i-2]};
        n_run++;
        if (d_valid !== 1'b1 || d_data !== exp_d || d_ovf !== 1'b0) begin
          n_fail++;
          $display("FAIL passthrough[%0d] got v=%b d=%h o=%b want 1 %h 0",
                   i-2, d_valid, d_data, d_ovf, exp_d);
        end
      end
    end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_rounding();
    logic [13:0] vin[8]  = '{14'h0060, 14'h0060, 14'h0060, 14'h0060,
                             14'h0020, 14'h0020, 14'h3FE0, 14'h3FE0};
    logic [1:0]  vm[8]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3};
    logic [7:0]  vexp[8] = '{8'h01, 8'h02, 8'h02, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h00};
    for (int i = 0; i < 8; i++) begin
      send(vin[i], vm[i], 1'b1);
      n_run++;
      if (a_valid !== 1'b1 || a_data !== vexp[i] || a_ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL round[%0d] in=%h mode=%0d got v=%b d=%h o=%b want 1 %h 0",
                 i, vin[i], vm[i], a_valid, a_data, a_ovf, vexp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    send(14'h1FFF, 2'd1, 1'b1);
    n_run++;
    if (a_data !== 8'h7F || a_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sat got d=%h o=%b want 7f 1", a_data, a_ovf);
    end
    send(14'h1FFF, 2'd1, 1'b0);
    n_run++;
    if (a_data !== 8'h80 || a_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_wrap got d=%h o=%b want 80 1", a_data, a_ovf);
    end
    send(14'h1FFF, 2'd0, 1'b1);
    n_run++;
    if (a_data !== 8'h7F || a_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_trunc got d=%h o=%b want 7f 0", a_data, a_ovf);
    end
    tick();
    n_run++;
    if (a_cnt !== 4'd2) begin n_fail++; $display("FAIL ovf_count got %0d want 2", a_cnt); end
  endtask

  task automatic test_counter();
    data = 14'h1FFF; mode = 2'd1; sat = 1'b1;
    for (int i = 0; i < 24; i++) begin
      valid = (i < 20);
      tick();
    end
    valid = 1'b0;
    n_run++;
    if (a_cnt !== 4'd15) begin n_fail++; $display("FAIL cnt_saturate got %0d want 15", a_cnt); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_run++;
    if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL cnt_clear got %0d want 0", a_cnt); end
    send(14'h1FFF, 2'd1, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_run++;
    if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL cnt_clr_priority got %0d want 0", a_cnt); end
    tick();
    n_run++;
    if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL cnt_clr_late got %0d want 0", a_cnt); end
    send(14'h1FFF, 2'd1, 1'b1);
    tick();
    n_run++;
    if (a_cnt !== 4'd1) begin n_fail++; $display("FAIL cnt_increment got %0d want 1", a_cnt); end
  endtask

  task automatic test_bubble();
    mode = 2'd0; sat = 1'b1;
    valid = 1'b1; data = 14'h0040; tick();
    valid = 1'b0; tick();
    valid = 1'b1; data = 14'h0080; tick();
    valid = 1'b0;
    n_run++;
    if (a_valid !== 1'b1 || a_data !== 8'h01) begin
      n_fail++; $display("FAIL bubble_first got v=%b d=%h want 1 01", a_valid, a_data);
    end
    tick();
    n_run++;
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_gap got v=%b want 0", a_valid); end
    tick();
    n_run++;
    if (a_valid !== 1'b1 || a_data !== 8'h02) begin
      n_fail++; $display("FAIL bubble_second got v=%b d=%h want 1 02", a_valid, a_data);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    mode = 2'd1; sat = 1'b0;
    valid = 1'b1; data = 14'h1FFF; tick();
    rst = 1'b1; data = 14'h0080; tick();
    rst = 1'b0; valid = 1'b0;
    n_run++;
    if (a_valid !== 1'b0 || a_data !== 8'h00 || a_ovf !== 1'b0 || a_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL midrst_state got v=%b d=%h o=%b c=%0d want 0 00 0 0",
               a_valid, a_data, a_ovf, a_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_run++;
      if (a_valid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_drain[%0d] got v=%b want 0", i, a_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; data = '0; mode = '0; sat = 1'b0; clr = 1'b0;
    test_reset();
    test_passthrough();
    test_rounding();
    test_overflow();
    test_counter();
    test_bubble();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
